exe_mem: RTL and testbench

EXE_MEM -- requirements
Module: exe_mem

---
 rtl/exe_mem.sv | 147 ++++++++++++++
 tb/tb_exe_mem.sv | 220 ++++++++++++++++++++++
 2 files changed

// File: rtl/exe_mem.sv
// EXE->MEM pipeline register with a two-entry skid buffer, registered ready,
// x0 write suppression and a saturating back-pressure counter.
`ifndef RADDR_WIDTH
`define RADDR_WIDTH 5
`endif
`ifndef RDATA_WIDTH
`define RDATA_WIDTH 32
`endif
`ifndef ZERO_REG
`define ZERO_REG 5'd0
`endif
`ifndef ZERO
`define ZERO 32'd0
`endif
`ifndef WRITE_DISABLE
`define WRITE_DISABLE 1'b0
`endif

module exe_mem #(
    parameter int STALL_CNT_W = 8
) (
    input  logic                    clk_i,
    input  logic                    rst_i,
    input  logic                    flush_i,
    // Handshake: a transfer happens on an edge where valid and ready are both 1.
    input  logic                    valid_i,
    output logic                    ready_o,
    input  logic [`RADDR_WIDTH-1:0] reg_waddr_i,
    input  logic                    reg_we_i,
    input  logic [`RDATA_WIDTH-1:0] reg_wdata_i,
    output logic                    valid_o,
    input  logic                    ready_i,
    output logic [`RADDR_WIDTH-1:0] reg_waddr_o,
    output logic                    reg_we_o,
    output logic [`RDATA_WIDTH-1:0] reg_wdata_o,
    output logic [STALL_CNT_W-1:0]  stall_cnt_o,
    output logic [1:0]              state_o
);

    typedef enum logic [1:0] {
        ST_EMPTY = 2'd0,
        ST_ONE   = 2'd1,
        ST_FULL  = 2'd2
    } state_t;

    typedef struct packed {
        logic [`RADDR_WIDTH-1:0] waddr;
        logic                    we;
        logic [`RDATA_WIDTH-1:0] wdata;
    } entry_t;

    state_t                 r_state;
    state_t                 w_state_nxt;
    logic                   r_ready;
    entry_t                 r_main;
    entry_t                 r_skid;
    logic [STALL_CNT_W-1:0] r_stall_cnt;

    logic   w_valid;
    logic   w_in_hs;
    logic   w_out_hs;
    logic   w_load_main;
    logic   w_load_skid;
    logic   w_skid_to_main;
    entry_t w_cap;

    assign w_valid  = (r_state != ST_EMPTY);
    assign w_in_hs  = valid_i & r_ready;
    assign w_out_hs = w_valid & ready_i;

    // Writes to the hard-wired zero register are kept but neutralised here.
    assign w_cap.waddr = reg_waddr_i;
    assign w_cap.we    = (reg_waddr_i == `ZERO_REG) ? `WRITE_DISABLE : reg_we_i;
    assign w_cap.wdata = reg_wdata_i;

    always_comb begin
        w_state_nxt    = r_state;
        w_load_main    = 1'b0;
        w_load_skid    = 1'b0;
        w_skid_to_main = 1'b0;
        case (r_state)
            ST_EMPTY: begin
                if (w_in_hs) begin
                    w_load_main = 1'b1;
                    w_state_nxt = ST_ONE;
                end
            end
            ST_ONE: begin
                if (w_in_hs && w_out_hs) begin
                    w_load_main = 1'b1;
                end else if (w_in_hs) begin
                    w_load_skid = 1'b1;
                    w_state_nxt = ST_FULL;
                end else if (w_out_hs) begin
                    w_state_nxt = ST_EMPTY;
                end
            end
            ST_FULL: begin
                if (w_out_hs) begin
                    w_skid_to_main = 1'b1;
                    w_state_nxt    = ST_ONE;
                end
            end
            default: w_state_nxt = ST_EMPTY;
        endcase
        if (flush_i) begin
            w_state_nxt    = ST_EMPTY;
            w_load_main    = 1'b0;
            w_load_skid    = 1'b0;
            w_skid_to_main = 1'b0;
        end
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            r_state     <= ST_EMPTY;
            r_ready     <= 1'b1;
            r_main      <= '0;
            r_skid      <= '0;
            r_stall_cnt <= '0;
        end else begin
            r_state <= w_state_nxt;
            // ready is registered from the next state so it never depends on ready_i combinationally.
            r_ready <= (w_state_nxt != ST_FULL);
            if (w_load_main) begin
                r_main <= w_cap;
            end else if (w_skid_to_main) begin
                r_main <= r_skid;
            end
            if (w_load_skid) begin
                r_skid <= w_cap;
            end
            if (w_valid && !ready_i && (r_stall_cnt != {STALL_CNT_W{1'b1}})) begin
                r_stall_cnt <= r_stall_cnt + 1'b1;
            end
        end
    end

    assign ready_o     = r_ready;
    assign valid_o     = w_valid;
    assign reg_waddr_o = w_valid ? r_main.waddr : `ZERO_REG;
    assign reg_we_o    = w_valid ? r_main.we    : `WRITE_DISABLE;
    assign reg_wdata_o = w_valid ? r_main.wdata : `ZERO;
    assign stall_cnt_o = r_stall_cnt;
    assign state_o     = r_state;

endmodule

// File: tb/tb_exe_mem.sv
// Directed bench for exe_mem: streaming, back-pressure, x0 suppression, flush,
// reset in FULL and counter saturation on a narrow-counter instance.
`ifndef RADDR_WIDTH
`define RADDR_WIDTH 5
`endif
`ifndef RDATA_WIDTH
`define RDATA_WIDTH 32
`endif

module tb_exe_mem;

    logic                    clk_i = 1'b0;
    logic                    rst_i;
    logic                    flush_i;
    logic                    valid_i;
    logic [`RADDR_WIDTH-1:0] reg_waddr_i;
    logic                    reg_we_i;
    logic [`RDATA_WIDTH-1:0] reg_wdata_i;
    logic                    ready_i;

    logic                    ready_o;
    logic                    valid_o;
    logic [`RADDR_WIDTH-1:0] reg_waddr_o;
    logic                    reg_we_o;
    logic [`RDATA_WIDTH-1:0] reg_wdata_o;
    logic [7:0]              stall_cnt_o;
    logic [1:0]              state_o;

    logic                    s_ready_o;
    logic                    s_valid_o;
    logic [`RADDR_WIDTH-1:0] s_reg_waddr_o;
    logic                    s_reg_we_o;
    logic [`RDATA_WIDTH-1:0] s_reg_wdata_o;
    logic [3:0]              s_stall_cnt_o;
    logic [1:0]              s_state_o;

    int n_pass  = 0;
    int n_total = 0;

    always #5 clk_i = ~clk_i;

    exe_mem dut (
        .clk_i(clk_i), .rst_i(rst_i), .flush_i(flush_i),
        .valid_i(valid_i), .ready_o(ready_o),
        .reg_waddr_i(reg_waddr_i), .reg_we_i(reg_we_i), .reg_wdata_i(reg_wdata_i),
        .valid_o(valid_o), .ready_i(ready_i),
        .reg_waddr_o(reg_waddr_o), .reg_we_o(reg_we_o), .reg_wdata_o(reg_wdata_o),
        .stall_cnt_o(stall_cnt_o), .state_o(state_o)
    );

    exe_mem #(.STALL_CNT_W(4)) dut_sat (
        .clk_i(clk_i), .rst_i(rst_i), .flush_i(flush_i),
        .valid_i(valid_i), .ready_o(s_ready_o),
        .reg_waddr_i(reg_waddr_i), .reg_we_i(reg_we_i), .reg_wdata_i(reg_wdata_i),
        .valid_o(s_valid_o), .ready_i(ready_i),
        .reg_waddr_o(s_reg_waddr_o), .reg_we_o(s_reg_we_o), .reg_wdata_o(s_reg_wdata_o),
        .stall_cnt_o(s_stall_cnt_o), .state_o(s_state_o)
    );

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_total++;
        assert (obs === exp) n_pass++;
        else $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    endtask

    // Advance one edge, then let outputs settle before checking.
    task automatic tick();
        @(posedge clk_i);
        #1;
    endtask

    task automatic send(input logic [4:0] a, input logic we, input logic [31:0] d);
        valid_i     = 1'b1;
        reg_waddr_i = a;
        reg_we_i    = we;
        reg_wdata_i = d;
    endtask

    task automatic idle();
        valid_i     = 1'b0;
        reg_waddr_i = '0;
        reg_we_i    = 1'b0;
        reg_wdata_i = '0;
    endtask

    task automatic chk_out(input string tag, input logic v, input logic [4:0] a,
                           input logic we, input logic [31:0] d);
        chk({tag, "_valid"}, 64'(valid_o), 64'(v));
        chk({tag, "_waddr"}, 64'(reg_waddr_o), 64'(a));
        chk({tag, "_we"}, 64'(reg_we_o), 64'(we));
        chk({tag, "_wdata"}, 64'(reg_wdata_o), 64'(d));
    endtask

    initial begin
        logic [4:0]  exp_a;
        logic [31:0] exp_d;
        rst_i   = 1'b1;
        flush_i = 1'b0;
        ready_i = 1'b0;
        idle();
        tick();
        tick();
        rst_i = 1'b0;
        chk_out("reset", 1'b0, 5'd0, 1'b0, 32'd0);
        chk("reset_ready", 64'(ready_o), 64'd1);
        chk("reset_stall", 64'(stall_cnt_o), 64'd0);
        chk("reset_state", 64'(state_o), 64'd0);
        chk("reset_sat_stall", 64'(s_stall_cnt_o), 64'd0);

        // Streaming A..D back to back.
        ready_i = 1'b1;
        for (int i = 1; i <= 4; i++) begin
            exp_a = 5'(i);
            exp_d = 32'(i * 32'h11);
            send(exp_a, 1'b1, exp_d);
            tick();
            chk_out($sformatf("stream%0d", i), 1'b1, exp_a, 1'b1, exp_d);
            chk($sformatf("stream%0d_ready", i), 64'(ready_o), 64'd1);
        end
        idle();
        tick();
        chk("stream_drain_valid", 64'(valid_o), 64'd0);
        chk("stream_stall", 64'(stall_cnt_o), 64'd0);

        // Back-pressure: A then B held, released after three stalled cycles.
        ready_i = 1'b0;
        send(5'd5, 1'b1, 32'h55);
        tick();
        chk("bp_one_state", 64'(state_o), 64'd1);
        chk("bp_one_ready", 64'(ready_o), 64'd1);
        send(5'd6, 1'b1, 32'h66);
        tick();
        idle();
        chk("bp_full_ready", 64'(ready_o), 64'd0);
        chk("bp_full_state", 64'(state_o), 64'd2);
        chk_out("bp_full_head", 1'b1, 5'd5, 1'b1, 32'h55);
        chk("bp_stall1", 64'(stall_cnt_o), 64'd1);
        tick();
        tick();
        chk("bp_stall3", 64'(stall_cnt_o), 64'd3);
        chk_out("bp_release_a", 1'b1, 5'd5, 1'b1, 32'h55);
        ready_i = 1'b1;
        tick();
        chk_out("bp_release_b", 1'b1, 5'd6, 1'b1, 32'h66);
        chk("bp_release_ready", 64'(ready_o), 64'd1);
        tick();
        chk("bp_empty_valid", 64'(valid_o), 64'd0);
        chk("bp_stall_final", 64'(stall_cnt_o), 64'd3);

        // x0 write suppression, then a we=0 entry keeps its slot.
        send(5'd0, 1'b1, 32'hDEADBEEF);
        tick();
        chk_out("x0", 1'b1, 5'd0, 1'b0, 32'hDEADBEEF);
        send(5'd7, 1'b0, 32'h77);
        tick();
        chk_out("we0_entry", 1'b1, 5'd7, 1'b0, 32'h77);
        idle();
        tick();

        // Flush in FULL with a same-cycle valid_i.
        ready_i = 1'b0;
        send(5'd8, 1'b1, 32'h88);
        tick();
        send(5'd9, 1'b1, 32'h99);
        tick();
        chk("flush_pre_state", 64'(state_o), 64'd2);
        chk("flush_pre_stall", 64'(stall_cnt_o), 64'd4);
        flush_i = 1'b1;
        send(5'd10, 1'b1, 32'hAA);
        tick();
        flush_i = 1'b0;
        chk_out("flush", 1'b0, 5'd0, 1'b0, 32'd0);
        chk("flush_ready", 64'(ready_o), 64'd1);
        chk("flush_stall_kept", 64'(stall_cnt_o), 64'd5);
        ready_i = 1'b1;
        send(5'd11, 1'b1, 32'hBB);
        tick();
        chk_out("post_flush", 1'b1, 5'd11, 1'b1, 32'hBB);
        idle();
        tick();
        chk("post_flush_empty", 64'(valid_o), 64'd0);

        // Reset while FULL.
        ready_i = 1'b0;
        send(5'd12, 1'b1, 32'hCC);
        tick();
        send(5'd13, 1'b1, 32'hDD);
        tick();
        chk("rst_pre_state", 64'(state_o), 64'd2);
        idle();
        rst_i = 1'b1;
        tick();
        rst_i = 1'b0;
        chk_out("rst_full", 1'b0, 5'd0, 1'b0, 32'd0);
        chk("rst_full_ready", 64'(ready_o), 64'd1);
        chk("rst_full_stall", 64'(stall_cnt_o), 64'd0);
        ready_i = 1'b1;
        tick();
        chk("rst_no_stale1", 64'(valid_o), 64'd0);
        tick();
        chk("rst_no_stale2", 64'(valid_o), 64'd0);

        // Saturation: 20 stalled cycles on both instances.
        ready_i = 1'b0;
        send(5'd14, 1'b1, 32'hEE);
        tick();
        idle();
        for (int i = 0; i < 20; i++) tick();
        chk("sat_narrow", 64'(s_stall_cnt_o), 64'd15);
        chk("sat_wide", 64'(stall_cnt_o), 64'd20);
        for (int i = 0; i < 3; i++) tick();
        chk("sat_narrow_hold", 64'(s_stall_cnt_o), 64'd15);
        chk("sat_wide_more", 64'(stall_cnt_o), 64'd23);
        chk_out("sat_head", 1'b1, 5'd14, 1'b1, 32'hEE);

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule
